// File: rtl/rect_filler.sv
// Rectangle fill engine: walks an inclusive rectangle row-major in 8-pixel bursts
// and emits one address-FIFO command plus two 128-bit write-data beats per burst.
module rect_filler #(
  parameter int FB_HEIGHT = 768,
  parameter int FB_WIDTH  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [9:0]   x0,
  input  logic [9:0]   y0,
  input  logic [9:0]   x1,
  input  logic [9:0]   y1,
  input  logic [23:0]  color,
  input  logic [31:0]  frame_base,
  output logic         ready,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en
);

  localparam logic [9:0] Y_MAX = 10'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, W1, W2} state_t;

  state_t      state, state_next;
  logic [9:0]  x0_r, x1_r, y0_r, y1_r;
  logic [23:0] color_r;
  logic [5:0]  fb_r;
  logic [9:0]  cur_y;
  logic [6:0]  cur_g;
  logic [9:0]  y1_eff;
  logic        accept, rect_empty, w1_fire, w2_fire;
  logic        row_more, col_more;
  logic        unused_bits;

  // Only bits [27:22] of the base matter; the row pitch is baked into the address layout.
  assign unused_bits = (^{frame_base[31:28], frame_base[21:0]}) ^ (FB_WIDTH != 1024);

  assign y1_eff     = (y1_r > Y_MAX) ? Y_MAX : y1_r;
  assign rect_empty = (x0_r > x1_r) || (y0_r > y1_eff);
  assign col_more   = cur_g < x1_r[9:3];
  assign row_more   = cur_y < y1_eff;
  assign ready      = (state == IDLE);

  // Byte-enable mask for one half burst: a pixel outside [x0, x1] is fully masked.
  function automatic logic [15:0] half_mask(input logic [6:0] g, input logic hi,
                                            input logic [9:0] lo_x, input logic [9:0] hi_x);
    logic [9:0] px;
    half_mask = '0;
    for (int q = 0; q < 4; q++) begin
      px = {g, hi, 2'(q)};
      half_mask[4*q +: 4] = ((px < lo_x) || (px > hi_x)) ? 4'hF : 4'h0;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    w1_fire    = 1'b0;
    w2_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = rect_empty ? IDLE : W1;
      W1: begin
        if (!af_full && !wdf_full) begin
          w1_fire    = 1'b1;
          state_next = W2;
        end
      end
      W2: begin
        if (!wdf_full) begin
          w2_fire    = 1'b1;
          state_next = (col_more || row_more) ? W1 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes and payload are registered so the FIFOs see clean, glitch-free writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r         <= '0;
      x1_r         <= '0;
      y0_r         <= '0;
      y1_r         <= '0;
      color_r      <= '0;
      fb_r         <= '0;
      cur_y        <= '0;
      cur_g        <= '0;
      af_wr_en     <= 1'b0;
      wdf_wr_en    <= 1'b0;
      af_cmd_din   <= '0;
      af_addr_din  <= '0;
      wdf_din      <= '0;
      wdf_mask_din <= 16'hFFFF;
    end else begin
      af_wr_en  <= w1_fire;
      wdf_wr_en <= w1_fire || w2_fire;
      if (accept) begin
        x0_r    <= x0;
        x1_r    <= x1;
        y0_r    <= y0;
        y1_r    <= y1;
        color_r <= color;
        fb_r    <= frame_base[27:22];
      end
      if (state == SETUP) begin
        cur_y <= y0_r;
        cur_g <= x0_r[9:3];
      end
      if (w1_fire) begin
        af_cmd_din   <= 3'b000;
        af_addr_din  <= {6'b0, fb_r, cur_y, cur_g, 2'b00};
        wdf_din      <= {4{8'h00, color_r}};
        wdf_mask_din <= half_mask(cur_g, 1'b0, x0_r, x1_r);
      end
      if (w2_fire) begin
        wdf_din      <= {4{8'h00, color_r}};
        wdf_mask_din <= half_mask(cur_g, 1'b1, x0_r, x1_r);
        if (col_more) begin
          cur_g <= cur_g + 7'd1;
        end else if (row_more) begin
          cur_y <= cur_y + 10'd1;
          cur_g <= x0_r[9:3];
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_filler.sv
// Scoreboard bench for rect_filler: stimulus queues expected bursts, a negedge
// monitor pops them as the FIFO strobes appear.
module tb_rect_filler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [9:0]   x0, y0, x1, y1;
  logic [23:0]  color;
  logic [31:0]  frame_base;
  logic         ready;
  logic         af_full, wdf_full;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         af_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         wdf_wr_en;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  m;
  } wdf_t;

  logic [30:0] exp_af[$];
  wdf_t        exp_wdf[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          af_cnt   = 0;
  int          wdf_cnt  = 0;
  logic [30:0] last_addr = '0;

  always #5 clk = ~clk;

  rect_filler dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .color(color), .frame_base(frame_base), .ready(ready),
    .af_full(af_full), .wdf_full(wdf_full),
    .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en)
  );

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (af_wr_en) begin
        af_cnt++;
        last_addr = af_addr_din;
        if (exp_af.size() == 0) begin
          check_output("af_unexpected", 128'(af_addr_din), 128'h0);
          if (af_addr_din == '0) begin
            n_fail++;
            $display("[TB] FAIL af_unexpected: got a write, expected none");
          end
        end else begin
          check_output("af_addr", 128'(af_addr_din), 128'(exp_af.pop_front()));
          check_output("af_cmd", 128'(af_cmd_din), 128'h0);
        end
      end
      if (wdf_wr_en) begin
        wdf_cnt++;
        if (exp_wdf.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL wdf_unexpected: got a write, expected none");
        end else begin
          wdf_t e;
          e = exp_wdf.pop_front();
          check_output("wdf_din", wdf_din, e.d);
          check_output("wdf_mask", 128'(wdf_mask_din), 128'(e.m));
        end
      end
    end
  end

  // Reference fill: clamp y1, walk rows and 8-pixel groups, mask pixels outside [x0,x1].
  task automatic push_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [23:0] col, input logic [31:0] fb);
    int   ye;
    wdf_t w;
    ye = (ay1 > 767) ? 767 : ay1;
    if (ax0 > ax1 || ay0 > ye) return;
    for (int y = ay0; y <= ye; y++) begin
      for (int g = ax0 / 8; g <= ax1 / 8; g++) begin
        exp_af.push_back({6'b0, fb[27:22], 10'(y), 7'(g), 2'b00});
        for (int h = 0; h < 2; h++) begin
          w.d = {4{8'h00, col}};
          w.m = '0;
          for (int q = 0; q < 4; q++) begin
            int px;
            px = g * 8 + h * 4 + q;
            if (px < ax0 || px > ax1) w.m[4*q +: 4] = 4'hF;
          end
          exp_wdf.push_back(w);
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic [9:0] ax0, input logic [9:0] ay0, input logic [9:0] ax1,
                                input logic [9:0] ay1, input logic [23:0] col, input logic [31:0] fb);
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = col; frame_base = fb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("ready_timeout", 128'(ready), 128'h1);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ready"}, 128'(ready), 128'h1);
    check_output({tag, "_af_wr_en"}, 128'(af_wr_en), 128'h0);
    check_output({tag, "_wdf_wr_en"}, 128'(wdf_wr_en), 128'h0);
    check_output({tag, "_af_cmd"}, 128'(af_cmd_din), 128'h0);
    check_output({tag, "_af_addr"}, 128'(af_addr_din), 128'h0);
    check_output({tag, "_wdf_din"}, wdf_din, 128'h0);
    check_output({tag, "_wdf_mask"}, 128'(wdf_mask_din), 128'hFFFF);
  endtask

  task automatic check_drained(input string tag);
    check_output({tag, "_af_left"}, 128'(exp_af.size()), 128'h0);
    check_output({tag, "_wdf_left"}, 128'(exp_wdf.size()), 128'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    wdf_t w;
    rst = 1'b1; start = 1'b0; af_full = 1'b0; wdf_full = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0; frame_base = '0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    @(negedge clk);

    // Single pixel with hand-computed burst and latency checks.
    exp_af.push_back(31'h200400);
    w.d = {4{32'h00123456}}; w.m = 16'hFFFF; exp_wdf.push_back(w);
    w.m = 16'hFF0F;                          exp_wdf.push_back(w);
    apply_stimulus(10'd5, 10'd2, 10'd5, 10'd2, 24'h123456, 32'h0100_0000);
    @(negedge clk);
    @(negedge clk);
    check_output("lat_no_early_af", 128'(af_wr_en), 128'h0);
    @(negedge clk);
    check_output("lat_af_at_2", 128'(af_wr_en), 128'h1);
    check_output("busy_ready_low", 128'(ready), 128'h0);
    @(negedge clk);
    check_output("w2_strobe", 128'(wdf_wr_en), 128'h1);
    check_output("ready_after_w2", 128'(ready), 128'h1);
    // Back-to-back start in the cycle ready rises.
    push_fill(8, 1, 15, 1, 24'hABCDEF, 32'h0100_0000);
    apply_stimulus(10'd8, 10'd1, 10'd15, 10'd1, 24'hABCDEF, 32'h0100_0000);
    wait_ready(20);
    check_drained("b2b");

    // Full row: 128 bursts, unmasked, ending at group 127.
    base = af_cnt;
    n = wdf_cnt;
    push_fill(0, 0, 1023, 0, 24'h00FF00, 32'h0);
    apply_stimulus(10'd0, 10'd0, 10'd1023, 10'd0, 24'h00FF00, 32'h0);
    wait_ready(400);
    check_output("row_af_count", 128'(af_cnt - base), 128'd128);
    check_output("row_wdf_count", 128'(wdf_cnt - n), 128'd256);
    check_output("row_last_addr", 128'(last_addr), 128'h1FC);
    check_drained("row");

    // Backpressure on both FIFOs.
    base = af_cnt;
    push_fill(0, 3, 15, 3, 24'h0F0F0F, 32'h0);
    af_full = 1'b1;
    apply_stimulus(10'd0, 10'd3, 10'd15, 10'd3, 24'h0F0F0F, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("bp_af_blocked", 128'({af_wr_en, wdf_wr_en}), 128'h0);
    end
    af_full = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!af_wr_en && n < 10);
    check_output("bp_af_resume", 128'(af_wr_en), 128'h1);
    wdf_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_wdf_blocked", 128'({af_wr_en, wdf_wr_en}), 128'h0);
    end
    wdf_full = 1'b0;
    wait_ready(20);
    check_output("bp_burst_count", 128'(af_cnt - base), 128'd2);
    check_drained("bp");

    // Degenerate x range: immediate return to idle, no writes.
    base = af_cnt;
    apply_stimulus(10'd9, 10'd0, 10'd3, 10'd0, 24'h111111, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_output("degen_ready", 128'(ready), 128'h1);
    repeat (3) @(negedge clk);
    check_output("degen_no_writes", 128'(af_cnt - base), 128'h0);

    // y1 beyond the framebuffer is clamped to the last row.
    base = af_cnt;
    push_fill(0, 766, 0, 800, 24'h222222, 32'h0);
    apply_stimulus(10'd0, 10'd766, 10'd0, 10'd800, 24'h222222, 32'h0);
    wait_ready(20);
    check_output("clamp_bursts", 128'(af_cnt - base), 128'd2);
    check_output("clamp_last_row", 128'(last_addr), 128'(31'(767) << 9));
    check_drained("clamp");

    // Reset in the middle of a 64x64 fill, then restart.
    base = af_cnt;
    push_fill(64, 100, 127, 163, 24'h333333, 32'h0FC0_0000);
    apply_stimulus(10'd64, 10'd100, 10'd127, 10'd163, 24'h333333, 32'h0FC0_0000);
    n = 0;
    while (af_cnt - base < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("mid_reached_10", 128'(af_cnt - base >= 10), 128'h1);
    #3 rst = 1'b1;
    #1 check_reset_values("async");
    exp_af.delete();
    exp_wdf.delete();
    @(negedge clk);
    #3 rst = 1'b0;
    base = af_cnt;
    n = wdf_cnt;
    repeat (5) @(negedge clk);
    check_output("no_residual_af", 128'(af_cnt - base), 128'h0);
    check_output("no_residual_wdf", 128'(wdf_cnt - n), 128'h0);
    check_output("post_rst_ready", 128'(ready), 128'h1);
    push_fill(64, 100, 127, 163, 24'h333333, 32'h0FC0_0000);
    apply_stimulus(10'd64, 10'd100, 10'd127, 10'd163, 24'h333333, 32'h0FC0_0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!af_wr_en && n < 10);
    check_output("restart_first_addr", 128'(af_addr_din), 128'h1F8C820);
    wait_ready(1200);
    check_drained("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_filler.md
RECT_FILLER -- requirements
Module: rect_filler

Interface
REQ-001 SHALL have parameter FB_HEIGHT, default 768: number of visible rows; y1 is clamped to FB_HEIGHT-1.
REQ-002 SHALL have parameter FB_WIDTH, default 1024: row pitch in pixels; fixed, not clampable.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request strobe, sampled only while ready=1.
REQ-006 SHALL have ports x0, y0, x1, y1  input  10 each  inclusive rectangle corners, captured on accepted start.
REQ-007 SHALL have port color  input  24  fill colour, captured on accepted start.
REQ-008 SHALL have port frame_base  input  32  framebuffer base; only bits [27:22] used, captured on accepted start.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have ports af_full, wdf_full  input  1 each  RequestController backpressure.
REQ-011 SHALL have ports af_cmd_din 3, af_addr_din 31, af_wr_en 1  output  address-FIFO write.
REQ-012 SHALL have ports wdf_din 128, wdf_mask_din 16, wdf_wr_en 1  output  write-data-FIFO write.

Function
REQ-013 SHALL implement FSM IDLE -> SETUP -> W1 -> W2 -> (W1 | IDLE).
REQ-014 IDLE: start=1 captures inputs and goes to SETUP; start while not in IDLE SHALL be ignored.
REQ-015 SETUP: clamp y1 to FB_HEIGHT-1; if x0>x1 or y0>y1 (after clamp), return to IDLE with no FIFO writes; else cur_y=y0, cur_g=x0[9:3], go to W1.
REQ-016 W1: when af_full=0 and wdf_full=0, assert af_wr_en and wdf_wr_en together for exactly one cycle (first 128-bit half) and go to W2; otherwise hold with both strobes low.
REQ-017 W2: when wdf_full=0, assert wdf_wr_en for one cycle (second half); otherwise hold.
REQ-018 After W2: if cur_g<x1[9:3], increment cur_g; else if cur_y<y1, increment cur_y and set cur_g=x0[9:3]; else go to IDLE.
REQ-019 Order SHALL be row-major, left to right; one burst (8 pixels) per W1/W2 pair; no burst SHALL be skipped or duplicated under any backpressure pattern.
REQ-020 af_cmd_din SHALL be 3'b000 (write) whenever af_wr_en=1.
REQ-021 af_addr_din SHALL be {6'b0, frame_base[27:22], cur_y[9:0], cur_g[6:0], 2'b00}.
REQ-022 Pixel p (0..7) of a burst SHALL be {8'h00, color}; W1 carries p=0..3 and W2 carries p=4..7, with pixel p%4 at wdf_din[32(p%4)+31 : 32(p%4)].
REQ-023 Mask bits [4(p%4)+3 : 4(p%4)] SHALL be 4'hF (byte not written) when cur_g*8+p < x0 or > x1, else 4'h0.
REQ-024 Strobes SHALL be registered outputs; wdf_din and wdf_mask_din SHALL be valid in every cycle wdf_wr_en=1.
REQ-025 Latency from accepted start to first af_wr_en SHALL be 2 cycles with no backpressure; throughput is 1 burst per 2 cycles.
REQ-026 x1=1023 SHALL terminate the row at cur_g=127 without counter wrap.
REQ-027 ready SHALL rise the cycle after the final W2 write; a start in that same cycle SHALL be accepted.

Reset
REQ-028 rst SHALL force IDLE immediately, ready=1, af_wr_en=0, wdf_wr_en=0, af_cmd_din=0, af_addr_din=0, wdf_din=0, wdf_mask_din=16'hFFFF, and clear all captured registers.
REQ-029 rst during W1/W2 SHALL abandon the fill; after release, no residual writes SHALL occur until a new start.

Verification
REQ-030 Reset: assert rst mid-cycle -> outputs at REQ-028 values asynchronously, ready=1 after release.
REQ-031 Single pixel, frame_base=0x01000000, x0=x1=5, y0=y1=2, color=0x123456: expect one af_wr_en with addr 0x200400, W1 mask 16'hFFFF, W2 mask 16'hFF0F, W2 bits [63:32]=0x00123456; expect ready 1 cycle later.
REQ-032 Full row x0=0, x1=1023, y0=y1=0: expect 128 af writes and 256 wdf writes, all masks 0, addresses stepping by 4, last address 0x1FC.
REQ-033 Backpressure: hold af_full=1 for 10 cycles in W1, then wdf_full=1 for 5 cycles in W2 -> no strobes while blocked; the total burst count is unchanged and no address repeats.
REQ-034 Degenerate inputs: x0=9, x1=3 -> zero writes and ready within 2 cycles; y0=766, y1=800, x0=x1=0 -> exactly 2 bursts, with rows 766 and 767.
REQ-035 Reset mid-fill of a 64x64 rectangle after 10 bursts -> strobes drop immediately; a new start after release produces the correct first address.
